// File: rtl/vedic_pkg.sv
// Shared widths, stage records and the final-stage combine for the pipelined
// 4x4 Vedic multiplier.
package vedic_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned HALF_W = 2;
    localparam int unsigned PP_W   = 4;
    localparam int unsigned PROD_W = 8;
    localparam int unsigned SUM_W  = PP_W + 1;
    localparam int unsigned HI_W   = PROD_W - HALF_W;

    // Stage 1: the four raw 2x2 partial products.
    typedef struct packed {
        logic              valid;
        logic [PP_W-1:0]   q0;
        logic [PP_W-1:0]   q1;
        logic [PP_W-1:0]   q2;
        logic [PP_W-1:0]   q3;
    } pp_stage_t;

    // Stage 2: cross terms already folded into s1.
    typedef struct packed {
        logic              valid;
        logic [PP_W-1:0]   q0;
        logic [PP_W-1:0]   q3;
        logic [SUM_W-1:0]  s1;
    } stage_t;

    // Max product is 225, so the 6-bit upper sum never carries out.
    function automatic logic [PROD_W-1:0] combine(input stage_t s);
        logic [HI_W-1:0] hi;
        hi = {s.q3, s.q0[PP_W-1:HALF_W]} + HI_W'(s.s1);
        return {hi, s.q0[HALF_W-1:0]};
    endfunction

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder used to build the 2x2 Vedic cell.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/vedic_2x2.sv
// 2x2 Urdhva-Tiryagbhyam multiplier cell: one AND for bit 0, two half adders
// for the vertical/crosswise columns.
module vedic_2x2
    import vedic_pkg::*;
(
    input  logic [HALF_W-1:0] a,
    input  logic [HALF_W-1:0] b,
    output logic [PP_W-1:0]   p
);

    logic cross_hi;
    logic cross_lo;
    logic top;
    logic c1;
    logic p1;
    logic p2;
    logic p3;

    assign cross_hi = a[1] & b[0];
    assign cross_lo = a[0] & b[1];
    assign top      = a[1] & b[1];

    half_adder u_ha_mid (.x(cross_hi), .y(cross_lo), .s(p1), .c(c1));
    half_adder u_ha_top (.x(top),      .y(c1),       .s(p2), .c(p3));

    assign p = {p3, p2, p1, a[0] & b[0]};

endmodule

// File: rtl/vedic_mult_pipe.sv
// Three-stage pipelined 4x4 Vedic multiplier with valid/ready on both sides;
// each stage loads when empty or when the stage downstream is loading.
module vedic_mult_pipe
    import vedic_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [PROD_W-1:0] P,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [PP_W-1:0] pp0;
    logic [PP_W-1:0] pp1;
    logic [PP_W-1:0] pp2;
    logic [PP_W-1:0] pp3;

    pp_stage_t st1;
    stage_t    st2;

    logic load1;
    logic load2;
    logic load3;
    logic accept;

    vedic_2x2 u_pp0 (.a(a[HALF_W-1:0]),    .b(b[HALF_W-1:0]),    .p(pp0));
    vedic_2x2 u_pp1 (.a(a[OP_W-1:HALF_W]), .b(b[HALF_W-1:0]),    .p(pp1));
    vedic_2x2 u_pp2 (.a(a[HALF_W-1:0]),    .b(b[OP_W-1:HALF_W]), .p(pp2));
    vedic_2x2 u_pp3 (.a(a[OP_W-1:HALF_W]), .b(b[OP_W-1:HALF_W]), .p(pp3));

    // Ready ripples back combinationally from out_ready; empty stages always load.
    assign load3    = !out_valid | out_ready;
    assign load2    = !st2.valid | load3;
    assign load1    = !st1.valid | load2;
    assign in_ready = !rst & load1;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            st1       <= '0;
            st2       <= '0;
            P         <= '0;
            out_valid <= 1'b0;
        end else begin
            if (load1) begin
                st1.valid <= accept;
                if (accept) begin
                    st1.q0 <= pp0;
                    st1.q1 <= pp1;
                    st1.q2 <= pp2;
                    st1.q3 <= pp3;
                end
            end
            if (load2) begin
                st2.valid <= st1.valid;
                if (st1.valid) begin
                    st2.q0 <= st1.q0;
                    st2.q3 <= st1.q3;
                    st2.s1 <= SUM_W'(st1.q1) + SUM_W'(st1.q2);
                end
            end
            if (load3) begin
                out_valid <= st2.valid;
                if (st2.valid) begin
                    P <= combine(st2);
                end
            end
        end
    end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Scoreboard bench for vedic_mult_pipe: accepted pairs push a*b, a separate
// monitor pops and compares on every output handshake.
module tb_vedic_mult_pipe;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] p;
    logic       out_valid;
    logic       out_ready;

    logic [7:0] sb[$];
    int         checks = 0;
    int         errors = 0;
    int         pops   = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_p = '0;

    vedic_mult_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .P         (p),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] x, input logic [3:0] y);
        int t;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        t        = 0;
        while (!in_ready && t < 50) begin
            step();
            t++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            step();
            t++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    // Reference model: plain unsigned multiply of every accepted pair.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready)
            sb.push_back(8'(a) * 8'(b));
    end

    always @(negedge clk) begin
        logic [7:0] exp;
        if (rst) begin
            sb.delete();
        end else if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output got %0d expected none", p);
            end else begin
                exp = sb.pop_front();
                check("product", 32'(p), 32'(exp));
                pops++;
            end
        end
    end

    // A presented product must not move while the consumer stalls it.
    always @(negedge clk) begin
        if (!rst && prev_stall) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_p", 32'(p), 32'(prev_p));
        end
        prev_stall <= !rst && out_valid && !out_ready;
        prev_p     <= p;
    end

    initial begin
        int base;
        rst       = 1'b1;
        a         = '0;
        b         = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        repeat (3) step();
        check("reset_p", 32'(p), 32'h00);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", 32'(in_ready), 32'd1);

        // Single 15x15 pulse: visible after the third edge, then gone.
        send(4'hF, 4'hF);
        check("lat_n", 32'(out_valid), 32'd0);
        step();
        check("lat_n1", 32'(out_valid), 32'd0);
        step();
        check("lat_n2_valid", 32'(out_valid), 32'd1);
        check("lat_n2_p", 32'(p), 32'hE1);
        step();
        check("lat_n3_valid", 32'(out_valid), 32'd0);

        // Exhaustive back-to-back sweep at full throughput.
        base = pops;
        for (int i = 0; i < 256; i++) begin
            a        = 4'(i >> 4);
            b        = 4'(i);
            in_valid = 1'b1;
            check("sweep_in_ready", 32'(in_ready), 32'd1);
            step();
        end
        in_valid = 1'b0;
        drain();
        check("sweep_count", 32'(pops - base), 32'd256);

        // Backpressure: fill all three stages with the consumer stalled.
        base      = pops;
        out_ready = 1'b0;
        send(4'd3, 4'd5);
        send(4'd7, 4'd9);
        send(4'd12, 4'd10);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_p", 32'(p), 32'h0F);
        a        = 4'd0;
        b        = 4'd6;
        in_valid = 1'b1;
        #1;
        check("bp_full_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold_p", 32'(p), 32'h0F);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        drain();
        check("bp_count", 32'(pops - base), 32'd4);

        // Random valid/ready toggling.
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            a         = 4'($urandom);
            b         = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset with three products in flight, then one fresh pair.
        out_ready = 1'b0;
        send(4'd9, 4'd9);
        send(4'd5, 4'd4);
        send(4'd1, 4'd13);
        check("mid_full_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_p", 32'(p), 32'h00);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        base      = pops;
        send(4'd2, 4'd8);
        repeat (2) step();
        check("mid_new_valid", 32'(out_valid), 32'd1);
        check("mid_new_p", 32'(p), 32'd16);
        drain();
        repeat (4) step();
        check("mid_new_count", 32'(pops - base), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
